// File: rtl/mem_access_unit.sv
// Memory stage of a small pipeline: issues one dmem/imem access per memory op, stalls upstream
// while it is outstanding, and drives the M/W latch. Faults are flagged stickily until reset.
module mem_access_unit #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] oIn,
    input  logic [31:0] dIn,
    input  logic        wMemIn,
    input  logic        wImemIn,
    input  logic        wRegIn,
    input  logic        lwIn,
    input  logic        ilwIn,
    input  logic [4:0]  rdIn,
    input  logic [4:0]  rsIn,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [11:0] dmemAddr,
    output logic [31:0] dmemWdata,
    input  logic [31:0] dmemRdata,
    input  logic        dmemAck,
    output logic        imemReq,
    output logic        imemWe,
    output logic [11:0] imemAddr,
    output logic [31:0] imemWdata,
    input  logic [31:0] imemRdata,
    input  logic        imemAck,
    output logic        stall,
    output logic [31:0] oOut,
    output logic [31:0] dataOut,
    output logic [4:0]  rdOut,
    output logic        wRegOut,
    output logic        lwOut,
    output logic        memFault
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;
    logic        mem_fault_q, mem_fault_d;
    logic [31:0] o_q, o_d, data_q, data_d;
    logic [4:0]  rd_q, rd_d;
    logic        wreg_q, wreg_d, lw_q, lw_d;

    // Decode with priority wImem > ilw > wMem > lw.
    logic mem_op, op_store, use_imem, in_range, ack_sel;
    logic [31:0] store_data, rdata_sel;

    assign mem_op    = wImemIn | ilwIn | wMemIn | lwIn;
    assign use_imem  = wImemIn | ilwIn;
    assign op_store  = wImemIn | (!ilwIn & wMemIn);
    assign in_range  = (oIn[31:12] == 20'd0);
    assign ack_sel   = use_imem ? imemAck : dmemAck;
    assign rdata_sel = use_imem ? imemRdata : dmemRdata;

    // Forward the value still sitting in the W stage if the store source matches it.
    assign store_data = (wreg_q && (rd_q == rsIn) && (rsIn != 5'd0)) ?
                        (lw_q ? data_q : o_q) : dIn;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            fault_q     <= 1'b0;
            mem_fault_q <= 1'b0;
            o_q         <= 32'd0;
            data_q      <= 32'd0;
            rd_q        <= 5'd0;
            wreg_q      <= 1'b0;
            lw_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
            mem_fault_q <= mem_fault_d;
            o_q         <= o_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
            wreg_q      <= wreg_d;
            lw_q        <= lw_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        mem_fault_d = mem_fault_q;
        o_d         = o_q;
        data_d      = data_q;
        rd_d        = rd_q;
        wreg_d      = wreg_q;
        lw_d        = lw_q;
        unique case (state_q)
            StIdle: begin
                if (!mem_op) begin
                    o_d    = oIn;
                    rd_d   = rdIn;
                    wreg_d = wRegIn;
                    lw_d   = lwIn;
                    data_d = 32'd0;
                end else begin
                    wreg_d  = 1'b0;
                    lw_d    = 1'b0;
                    cnt_d   = 8'd0;
                    wdata_d = store_data;
                    if (in_range) begin
                        fault_d = 1'b0;
                        state_d = StAccess;
                    end else begin
                        fault_d     = 1'b1;
                        mem_fault_d = 1'b1;
                        rdata_d     = 32'd0;
                        state_d     = StResp;
                    end
                end
            end
            StAccess: begin
                if (ack_sel) begin
                    rdata_d = op_store ? 32'd0 : rdata_sel;
                    state_d = StResp;
                end else if (cnt_q == TIMEOUT - 8'd1) begin
                    fault_d     = 1'b1;
                    mem_fault_d = 1'b1;
                    rdata_d     = 32'd0;
                    state_d     = StResp;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StResp: begin
                o_d     = oIn;
                rd_d    = rdIn;
                wreg_d  = wRegIn & !op_store & !fault_q;
                lw_d    = lwIn | ilwIn;
                data_d  = rdata_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Stall depends only on state and the op decode, never on the acks.
    always_comb begin
        stall   = 1'b0;
        dmemReq = 1'b0;
        dmemWe  = 1'b0;
        imemReq = 1'b0;
        imemWe  = 1'b0;
        unique case (state_q)
            StIdle:   stall = mem_op;
            StAccess: begin
                stall   = 1'b1;
                dmemReq = !use_imem;
                imemReq = use_imem;
                dmemWe  = !use_imem & op_store;
                imemWe  = use_imem & op_store;
            end
            default:  stall = 1'b0;
        endcase
    end

    assign dmemAddr  = oIn[11:0];
    assign imemAddr  = oIn[11:0];
    assign dmemWdata = wdata_q;
    assign imemWdata = wdata_q;
    assign oOut      = o_q;
    assign dataOut   = data_q;
    assign rdOut     = rd_q;
    assign wRegOut   = wreg_q;
    assign lwOut     = lw_q;
    assign memFault  = mem_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a table of ALU pass-through vectors followed by
// hand-written load/store/fault/reset sequences with a scripted memory responder.
module tb_mem_access_unit;

    localparam logic [7:0] TO = 8'd20;
    localparam logic [3:0] OP_NONE = 4'b0000;  // {wImem, ilw, wMem, lw}
    localparam logic [3:0] OP_LW   = 4'b0001;
    localparam logic [3:0] OP_SW   = 4'b0010;
    localparam logic [3:0] OP_ILW  = 4'b0100;
    localparam logic [3:0] OP_SWI  = 4'b1000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] oIn, dIn;
    logic        wMemIn, wImemIn, wRegIn, lwIn, ilwIn;
    logic [4:0]  rdIn, rsIn;
    logic        dmemReq, dmemWe, imemReq, imemWe;
    logic [11:0] dmemAddr, imemAddr;
    logic [31:0] dmemWdata, imemWdata, dmemRdata, imemRdata;
    logic        dmemAck, imemAck;
    logic        stall;
    logic [31:0] oOut, dataOut;
    logic [4:0]  rdOut;
    logic        wRegOut, lwOut, memFault;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .oIn(oIn), .dIn(dIn),
        .wMemIn(wMemIn), .wImemIn(wImemIn), .wRegIn(wRegIn), .lwIn(lwIn), .ilwIn(ilwIn),
        .rdIn(rdIn), .rsIn(rsIn),
        .dmemReq(dmemReq), .dmemWe(dmemWe), .dmemAddr(dmemAddr), .dmemWdata(dmemWdata),
        .dmemRdata(dmemRdata), .dmemAck(dmemAck),
        .imemReq(imemReq), .imemWe(imemWe), .imemAddr(imemAddr), .imemWdata(imemWdata),
        .imemRdata(imemRdata), .imemAck(imemAck),
        .stall(stall), .oOut(oOut), .dataOut(dataOut), .rdOut(rdOut),
        .wRegOut(wRegOut), .lwOut(lwOut), .memFault(memFault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] o;
        logic [4:0]  rd;
        logic        wreg;
        logic [31:0] exp_o;
        logic [4:0]  exp_rd;
        logic        exp_wreg;
    } alu_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] o, input logic [31:0] d, input logic [4:0] rd,
                         input logic [4:0] rs, input logic wreg, input logic [3:0] ops);
        oIn = o; dIn = d; rdIn = rd; rsIn = rs; wRegIn = wreg;
        {wImemIn, ilwIn, wMemIn, lwIn} = ops;
    endtask

    // Runs one stalled transaction from its IDLE cycle; returns at the first cycle with stall low.
    task automatic txn(input int ack_at, input logic ack_imem, input logic [31:0] rdata,
                       input int wrong_at, output int st_cyc, output int rq_cyc,
                       output logic [11:0] addr, output logic we, output logic [31:0] wd,
                       output logic port, output logic bub_wreg);
        logic done;
        done = 1'b0;
        st_cyc = 0; rq_cyc = 0; addr = '0; we = 1'b0; wd = '0; port = 1'b0; bub_wreg = 1'b1;
        dmemRdata = rdata; imemRdata = rdata;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clock);
            dmemAck = 1'b0; imemAck = 1'b0;
            if (!stall) begin
                chk("req_after_done", {30'd0, dmemReq, imemReq}, 32'd0);
                done = 1'b1;
            end else begin
                st_cyc++;
                if (dmemReq || imemReq) begin
                    rq_cyc++;
                    chk("req_onehot", {31'd0, dmemReq & imemReq}, 32'd0);
                    if (rq_cyc == 1) begin
                        bub_wreg = wRegOut;
                        port     = imemReq;
                        we       = imemReq ? imemWe : dmemWe;
                        addr     = imemReq ? imemAddr : dmemAddr;
                        wd       = imemReq ? imemWdata : dmemWdata;
                    end
                    if (rq_cyc == ack_at) begin
                        if (ack_imem) imemAck = 1'b1; else dmemAck = 1'b1;
                    end
                    if (rq_cyc == wrong_at) begin
                        if (ack_imem) dmemAck = 1'b1; else imemAck = 1'b1;
                    end
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL txn_timeout: stall still high after 400 cycles, required low");
        end
    endtask

    alu_vec_t    vecs[5];
    int          st, rq;
    logic [11:0] a;
    logic        we, pt, bw, seen;
    logic [31:0] wd;

    initial begin
        vecs[0] = '{32'h0000_0005, 5'd3,  1'b1, 32'h0000_0005, 5'd3,  1'b1};
        vecs[1] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 32'hFFFF_FFFF, 5'd31, 1'b0};
        vecs[2] = '{32'h0000_1000, 5'd1,  1'b1, 32'h0000_1000, 5'd1,  1'b1};
        vecs[3] = '{32'h0000_0000, 5'd0,  1'b0, 32'h0000_0000, 5'd0,  1'b0};
        vecs[4] = '{32'h1234_5678, 5'd17, 1'b1, 32'h1234_5678, 5'd17, 1'b1};

        reset = 1'b1;
        drive(32'd0, 32'd0, 5'd0, 5'd0, 1'b0, OP_NONE);
        dmemAck = 1'b0; imemAck = 1'b0; dmemRdata = '0; imemRdata = '0;
        #12;
        chk("rst_oOut", oOut, 32'd0);
        chk("rst_dataOut", dataOut, 32'd0);
        chk("rst_wRegOut", {31'd0, wRegOut}, 32'd0);
        chk("rst_lwOut", {31'd0, lwOut}, 32'd0);
        chk("rst_memFault", {31'd0, memFault}, 32'd0);
        chk("rst_reqs", {30'd0, dmemReq, imemReq}, 32'd0);
        chk("rst_stall_idle", {31'd0, stall}, 32'd0);
        drive(32'h10, 32'd0, 5'd1, 5'd0, 1'b1, OP_LW);
        #1 chk("rst_stall_decode", {31'd0, stall}, 32'd1);
        drive(32'd0, 32'd0, 5'd0, 5'd0, 1'b0, OP_NONE);
        @(negedge clock) reset = 1'b0;
        @(posedge clock); #1;

        // ALU pass-through, one cycle each
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].o, 32'd0, vecs[i].rd, 5'd0, vecs[i].wreg, OP_NONE);
            @(negedge clock);
            chk("alu_stall", {31'd0, stall}, 32'd0);
            @(posedge clock); #1;
            chk("alu_oOut", oOut, vecs[i].exp_o);
            chk("alu_rdOut", {27'd0, rdOut}, {27'd0, vecs[i].exp_rd});
            chk("alu_wRegOut", {31'd0, wRegOut}, {31'd0, vecs[i].exp_wreg});
            chk("alu_dataOut", dataOut, 32'd0);
        end

        // lw, ack in the second request cycle
        drive(32'h10, 32'd0, 5'd4, 5'd0, 1'b1, OP_LW);
        txn(2, 1'b0, 32'hDEAD_BEEF, 0, st, rq, a, we, wd, pt, bw);
        chk("lw_stall_cycles", st, 3);
        chk("lw_req_cycles", rq, 2);
        chk("lw_addr", {20'd0, a}, 32'h010);
        chk("lw_we", {31'd0, we}, 32'd0);
        chk("lw_port", {31'd0, pt}, 32'd0);
        chk("lw_bubble", {31'd0, bw}, 32'd0);
        @(posedge clock); #1;
        chk("lw_dataOut", dataOut, 32'hDEAD_BEEF);
        chk("lw_lwOut", {31'd0, lwOut}, 32'd1);
        chk("lw_wRegOut", {31'd0, wRegOut}, 32'd1);
        chk("lw_rdOut", {27'd0, rdOut}, 32'd4);

        // sw forwarding from the load in W
        drive(32'h24, 32'h55, 5'd0, 5'd4, 1'b0, OP_SW);
        txn(1, 1'b0, 32'h7777_7777, 0, st, rq, a, we, wd, pt, bw);
        chk("swl_wdata", wd, 32'hDEAD_BEEF);
        chk("swl_we", {31'd0, we}, 32'd1);
        chk("swl_addr", {20'd0, a}, 32'h024);
        chk("swl_stall_cycles", st, 2);
        @(posedge clock); #1;
        chk("swl_dataOut", dataOut, 32'd0);
        chk("swl_wRegOut", {31'd0, wRegOut}, 32'd0);

        // ALU writes r7, then sw r7 forwards the ALU result
        drive(32'h1234, 32'd0, 5'd7, 5'd0, 1'b1, OP_NONE);
        @(posedge clock); #1;
        drive(32'h20, 32'd0, 5'd0, 5'd7, 1'b1, OP_SW);
        txn(1, 1'b0, 32'd0, 0, st, rq, a, we, wd, pt, bw);
        chk("sw_wdata", wd, 32'h1234);
        chk("sw_we", {31'd0, we}, 32'd1);
        chk("sw_addr", {20'd0, a}, 32'h020);
        chk("sw_bubble", {31'd0, bw}, 32'd0);
        @(posedge clock); #1;
        chk("sw_wRegOut", {31'd0, wRegOut}, 32'd0);

        // r0 is never forwarded; imem store
        drive(32'h999, 32'd0, 5'd0, 5'd0, 1'b1, OP_NONE);
        @(posedge clock); #1;
        drive(32'hABC, 32'hCAFE_F00D, 5'd0, 5'd0, 1'b0, OP_SWI);
        txn(1, 1'b1, 32'd0, 0, st, rq, a, we, wd, pt, bw);
        chk("swi_wdata", wd, 32'hCAFE_F00D);
        chk("swi_port", {31'd0, pt}, 32'd1);
        chk("swi_we", {31'd0, we}, 32'd1);
        chk("swi_addr", {20'd0, a}, 32'hABC);
        @(posedge clock); #1;

        // wImem outranks lw when both are set
        drive(32'h40, 32'h5A5A, 5'd0, 5'd0, 1'b0, 4'b1001);
        txn(1, 1'b1, 32'd0, 0, st, rq, a, we, wd, pt, bw);
        chk("prio_port", {31'd0, pt}, 32'd1);
        chk("prio_we", {31'd0, we}, 32'd1);
        @(posedge clock); #1;
        chk("prio_wRegOut", {31'd0, wRegOut}, 32'd0);

        // ilw with a stray dmem ack first, real imem ack in the third request cycle
        drive(32'h8, 32'd0, 5'd9, 5'd0, 1'b1, OP_ILW);
        txn(3, 1'b1, 32'h0BAD_F00D, 1, st, rq, a, we, wd, pt, bw);
        chk("ilw_stall_cycles", st, 4);
        chk("ilw_req_cycles", rq, 3);
        chk("ilw_port", {31'd0, pt}, 32'd1);
        chk("ilw_we", {31'd0, we}, 32'd0);
        @(posedge clock); #1;
        chk("ilw_dataOut", dataOut, 32'h0BAD_F00D);
        chk("ilw_lwOut", {31'd0, lwOut}, 32'd1);
        chk("ilw_wRegOut", {31'd0, wRegOut}, 32'd1);
        chk("ilw_rdOut", {27'd0, rdOut}, 32'd9);
        chk("ilw_memFault", {31'd0, memFault}, 32'd0);

        // ilw timeout
        drive(32'h8, 32'd0, 5'd5, 5'd0, 1'b1, OP_ILW);
        txn(0, 1'b1, 32'hFFFF_FFFF, 0, st, rq, a, we, wd, pt, bw);
        chk("to_stall_cycles", st, 21);
        chk("to_req_cycles", rq, 20);
        @(posedge clock); #1;
        chk("to_memFault", {31'd0, memFault}, 32'd1);
        chk("to_dataOut", dataOut, 32'd0);
        chk("to_wRegOut", {31'd0, wRegOut}, 32'd0);
        chk("to_lwOut", {31'd0, lwOut}, 32'd1);
        drive(32'h77, 32'd0, 5'd2, 5'd0, 1'b1, OP_NONE);
        @(negedge clock);
        chk("sticky_stall", {31'd0, stall}, 32'd0);
        @(posedge clock); #1;
        chk("sticky_memFault", {31'd0, memFault}, 32'd1);
        chk("sticky_wRegOut", {31'd0, wRegOut}, 32'd1);

        // reset while dmemReq is high
        drive(32'h30, 32'd0, 5'd6, 5'd0, 1'b1, OP_LW);
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            @(negedge clock);
            seen = dmemReq;
        end
        chk("rstacc_req_seen", {31'd0, seen}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rstacc_dmemReq", {31'd0, dmemReq}, 32'd0);
        chk("rstacc_wRegOut", {31'd0, wRegOut}, 32'd0);
        chk("rstacc_memFault", {31'd0, memFault}, 32'd0);
        chk("rstacc_oOut", oOut, 32'd0);
        chk("rstacc_stall", {31'd0, stall}, 32'd1);
        @(posedge clock); #1;
        reset = 1'b0;
        txn(1, 1'b0, 32'h1111_2222, 0, st, rq, a, we, wd, pt, bw);
        chk("post_rst_stall_cycles", st, 2);
        chk("post_rst_req_cycles", rq, 1);
        chk("post_rst_addr", {20'd0, a}, 32'h030);
        @(posedge clock); #1;
        chk("post_rst_dataOut", dataOut, 32'h1111_2222);
        chk("post_rst_rdOut", {27'd0, rdOut}, 32'd6);
        chk("post_rst_memFault", {31'd0, memFault}, 32'd0);

        // out-of-range lw faults without any request
        drive(32'h1000, 32'd0, 5'd8, 5'd0, 1'b1, OP_LW);
        txn(1, 1'b0, 32'h3333_3333, 0, st, rq, a, we, wd, pt, bw);
        chk("oor_stall_cycles", st, 1);
        chk("oor_req_cycles", rq, 0);
        @(posedge clock); #1;
        chk("oor_memFault", {31'd0, memFault}, 32'd1);
        chk("oor_dataOut", dataOut, 32'd0);
        chk("oor_wRegOut", {31'd0, wRegOut}, 32'd0);
        drive(32'd0, 32'd0, 5'd0, 5'd0, 1'b0, OP_NONE);
        repeat (2) @(posedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
